// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: requester count,
// FSM state encoding, the control-state struct and small index helpers.
package rr_arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Control state of the arbiter FSM, kept together so that a checker can
    // observe the whole control state through one signal.
    typedef struct packed {
        arb_state_t state;
        logic [1:0] ptr;
    } arb_ctl_t;

    // One-hot vector with only bit idx set.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

    // Next index in the rotating search order (3 wraps to 0).
    function automatic logic [1:0] idx_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: returns the first requester at or after ptr
// (wrapping modulo 4) whose request bit is set and not masked by exclude.
// Used both for a fresh pick from IDLE and for handover from an owner.
module rr_priority_pick
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       ptr,
    input  logic [N_REQ-1:0] exclude,
    output logic             found,
    output logic [1:0]       idx
);

    logic [N_REQ-1:0] cand;
    logic [1:0]       pos;

    assign cand = req & ~exclude;

    // Scan from farthest to nearest so the nearest hit in search order wins.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        pos   = ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = ptr + 2'(k);
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux among four requesters.
//
// Request/grant protocol: a requester holds req[i] high for as long as it
// wants the mux. grant[i] rises one cycle after it is picked and stays high
// while req[i] stays high, for at most MAX_HOLD consecutive cycles when
// another requester is waiting. Dropping req[i] releases the mux at the next
// edge. valid mirrors (grant != 0); S is the binary index of the owner and
// keeps its last value while idle. Y is IN[S] gated by valid, with no
// register between IN and Y.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] IN,
    output logic [N_REQ-1:0] grant,
    output logic [1:0]       S,
    output logic             valid,
    output logic             Y
);

    // Last hold_cnt value an owner may reach before its tenure expires.
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_ctl_t          ctl;
    logic [HOLD_W-1:0] hold_cnt;

    logic [N_REQ-1:0]  exclude;
    logic              pick_found;
    logic [1:0]        pick_idx;

    // While owning, the current owner is masked so that a pick always finds
    // a different requester (handover); from IDLE everyone competes.
    assign exclude = (ctl.state == OWN) ? grant : '0;

    rr_priority_pick u_pick (
        .req     (req),
        .ptr     (ctl.ptr),
        .exclude (exclude),
        .found   (pick_found),
        .idx     (pick_idx)
    );

    // Arbiter FSM: owner selection, tenure counting and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctl.state <= IDLE;
            ctl.ptr   <= 2'd0;
            hold_cnt  <= '0;
            grant     <= '0;
            S         <= 2'd0;
            valid     <= 1'b0;
        end else begin
            case (ctl.state)
                IDLE: begin
                    if (pick_found) begin
                        ctl.state <= OWN;
                        ctl.ptr   <= idx_next(pick_idx);
                        hold_cnt  <= '0;
                        grant     <= idx_to_onehot(pick_idx);
                        S         <= pick_idx;
                        valid     <= 1'b1;
                    end
                end
                OWN: begin
                    if (req[S] && (hold_cnt < HOLD_LAST)) begin
                        // Owner keeps the mux; tenure not yet used up.
                        hold_cnt <= hold_cnt + 1'b1;
                    end else if (pick_found) begin
                        // Release or expiry with someone else waiting.
                        ctl.ptr  <= idx_next(pick_idx);
                        hold_cnt <= '0;
                        grant    <= idx_to_onehot(pick_idx);
                        S        <= pick_idx;
                    end else if (req[S]) begin
                        // Expiry with no competitor: restart tenure, no bubble.
                        hold_cnt <= '0;
                    end else begin
                        // Release with nobody waiting.
                        ctl.state <= IDLE;
                        hold_cnt  <= '0;
                        grant     <= '0;
                        valid     <= 1'b0;
                    end
                end
                default: begin
                    ctl.state <= IDLE;
                    hold_cnt  <= '0;
                    grant     <= '0;
                    valid     <= 1'b0;
                end
            endcase
        end
    end

    // Data path: selected input bit, forced low while nobody owns the mux.
    assign Y = valid & IN[S];

endmodule
